hpdcache_mem_read_responder: RTL and testbench



---
 rtl/hpdcache_mem_read_responder.sv | 173 +++++++++++++++++
 tb/tb_hpdcache_mem_read_responder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/hpdcache_mem_read_responder.sv
// Memory-side responder for the HPDcache refill read interface: queues read requests
// and returns gapped burst beats from an internal word-addressed RAM with a preload port.
module hpdcache_mem_read_responder #(
    parameter int unsigned PA_WIDTH       = 49,
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned ID_WIDTH       = 7,
    parameter int unsigned MEM_DEPTH      = 1024,
    parameter int unsigned REQ_FIFO_DEPTH = 4,
    parameter int unsigned LATENCY        = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    output logic                         mem_req_read_ready_o,
    input  logic                         mem_req_read_valid_i,
    input  logic [PA_WIDTH-1:0]          mem_req_read_addr_i,
    input  logic [7:0]                   mem_req_read_len_i,
    input  logic [ID_WIDTH-1:0]          mem_req_read_id_i,
    input  logic                         mem_resp_read_ready_i,
    output logic                         mem_resp_read_valid_o,
    output logic [DATA_WIDTH-1:0]        mem_resp_read_data_o,
    output logic [ID_WIDTH-1:0]          mem_resp_read_id_o,
    output logic                         mem_resp_read_error_o,
    output logic                         mem_resp_read_last_o,
    input  logic                         init_we_i,
    input  logic [$clog2(MEM_DEPTH)-1:0] init_addr_i,
    input  logic [DATA_WIDTH-1:0]        init_data_i,
    output logic                         busy_o
);

    localparam int unsigned WORD_OFF = $clog2(DATA_WIDTH / 8);
    localparam int unsigned IDX_W    = $clog2(MEM_DEPTH);
    localparam int unsigned PTR_W    = $clog2(REQ_FIFO_DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;

    typedef struct packed {
        logic [PA_WIDTH-1:0] addr;
        logic [7:0]          len;
        logic [ID_WIDTH-1:0] id;
    } req_t;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_LOAD, S_BURST} state_e;

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    req_t                  fifo_q [REQ_FIFO_DEPTH];
    req_t                  push_req, head;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop, fifo_full, fifo_empty;

    state_e                state_q, state_d;
    logic [PA_WIDTH-1:0]   base_q, base_d;
    logic [7:0]            len_q, len_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [7:0]            beat_q, beat_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  err_q, err_d;
    logic                  last_q, last_d;

    logic [PA_WIDTH-1:0]   beat_idx;
    logic                  in_range;

    assign push_req   = {mem_req_read_addr_i, mem_req_read_len_i, mem_req_read_id_i};
    assign head       = fifo_q[rd_ptr_q];
    assign fifo_full  = (count_q == CNT_W'(REQ_FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push       = mem_req_read_valid_i && !fifo_full;

    // Ready depends only on current occupancy, never on a same-cycle pop.
    assign mem_req_read_ready_o = !fifo_full;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Word index never wraps: the base is already shifted down, so +255 fits in PA_WIDTH.
    assign beat_idx = base_q + PA_WIDTH'(beat_q);
    assign in_range = (beat_idx < PA_WIDTH'(MEM_DEPTH));

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        id_d    = id_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;
        last_d  = last_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    base_d  = head.addr >> WORD_OFF;
                    len_d   = head.len;
                    id_d    = head.id;
                    beat_d  = '0;
                    cnt_d   = 8'(LATENCY);
                    state_d = (LATENCY == 0) ? S_LOAD : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q <= 8'd1) state_d = S_LOAD;
            end
            S_LOAD: begin
                data_d  = in_range ? mem_q[beat_idx[IDX_W-1:0]] : '0;
                err_d   = !in_range;
                last_d  = (beat_q == len_q);
                state_d = S_BURST;
            end
            S_BURST: begin
                if (mem_resp_read_ready_i) begin
                    if (last_q) begin
                        state_d = S_IDLE;
                    end else begin
                        beat_d  = beat_q + 8'd1;
                        state_d = S_LOAD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= S_IDLE;
            base_q   <= '0;
            len_q    <= '0;
            id_q     <= '0;
            beat_q   <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            base_q   <= base_d;
            len_q    <= len_d;
            id_q     <= id_d;
            beat_q   <= beat_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            err_q    <= err_d;
            last_q   <= last_d;
        end
    end

    // Storage is not reset; a preload write landing with LOAD lets LOAD see the old word.
    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_ptr_q] <= push_req;
        if (init_we_i) mem_q[init_addr_i] <= init_data_i;
    end

    assign mem_resp_read_valid_o = (state_q == S_BURST);
    assign mem_resp_read_data_o  = data_q;
    assign mem_resp_read_id_o    = id_q;
    assign mem_resp_read_error_o = err_q;
    assign mem_resp_read_last_o  = last_q;
    assign busy_o                = !fifo_empty || (state_q != S_IDLE);

endmodule

// File: tb/tb_hpdcache_mem_read_responder.sv
// Directed bench for hpdcache_mem_read_responder with default parameters.
module tb_hpdcache_mem_read_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_ready, req_valid;
    logic [48:0] req_addr;
    logic [7:0]  req_len;
    logic [6:0]  req_id;
    logic        resp_ready, resp_valid, resp_err, resp_last;
    logic [63:0] resp_data;
    logic [6:0]  resp_id;
    logic        init_we;
    logic [9:0]  init_addr;
    logic [63:0] init_data;
    logic        busy;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hpdcache_mem_read_responder dut (
        .clk_i                 (clk),
        .rst_ni                (rst_n),
        .mem_req_read_ready_o  (req_ready),
        .mem_req_read_valid_i  (req_valid),
        .mem_req_read_addr_i   (req_addr),
        .mem_req_read_len_i    (req_len),
        .mem_req_read_id_i     (req_id),
        .mem_resp_read_ready_i (resp_ready),
        .mem_resp_read_valid_o (resp_valid),
        .mem_resp_read_data_o  (resp_data),
        .mem_resp_read_id_o    (resp_id),
        .mem_resp_read_error_o (resp_err),
        .mem_resp_read_last_o  (resp_last),
        .init_we_i             (init_we),
        .init_addr_i           (init_addr),
        .init_data_i           (init_data),
        .busy_o                (busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wr_ram(input logic [9:0] idx, input logic [63:0] d);
        init_we = 1'b1; init_addr = idx; init_data = d;
        step();
        init_we = 1'b0;
    endtask

    task automatic send_req(input logic [48:0] a, input logic [7:0] l, input logic [6:0] i);
        chk("req_rdy", req_ready, 1);
        req_valid = 1'b1; req_addr = a; req_len = l; req_id = i;
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_idle;
        int n = 0;
        while (busy && n < 100) begin step(); n++; end
        chk("idle", busy, 0);
    endtask

    // Waits for a beat, checks it, and consumes it (resp_ready must be 1).
    task automatic expect_beat(input string tag, input logic [63:0] d, input logic [6:0] id,
                               input logic e, input logic l);
        int n = 0;
        while (!resp_valid && n < 200) begin step(); n++; end
        chk({tag, "_vld"}, resp_valid, 1);
        chk({tag, "_data"}, resp_data, d);
        chk({tag, "_id"}, resp_id, id);
        chk({tag, "_err"}, resp_err, e);
        chk({tag, "_last"}, resp_last, l);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        int acc;
        logic stable;
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0; req_id = '0;
        resp_ready = 1'b0; init_we = 1'b0; init_addr = '0; init_data = '0;
        step(); step();
        chk("rst_vld", resp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rdy", req_ready, 1);
        chk("rst_data", resp_data, 0);
        chk("rst_last", resp_last, 0);
        chk("rst_err", resp_err, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) wr_ram(10'(i), 64'h1000 + 64'(i));
        wr_ram(10'd1023, 64'hABCD_0123);
        for (int i = 0; i < 4; i++) wr_ram(10'(16 + i), 64'h2000 + 64'(i));
        resp_ready = 1'b1;

        // 8-beat burst: first beat LATENCY+2 = 5 cycles after the pop cycle
        send_req(49'h0, 8'd7, 7'h05);
        n = 0;
        while (!resp_valid && n < 20) begin step(); n++; end
        chk("first_lat", 64'(n), 5);
        expect_beat("b0", 64'h1000, 7'h05, 1'b0, 1'b0);
        chk("gap", resp_valid, 0);
        for (int b = 1; b < 8; b++)
            expect_beat("burst", 64'h1000 + 64'(b), 7'h05, 1'b0, (b == 7));
        wait_idle();

        // Top of RAM then out of range
        send_req(49'h1FF8, 8'd1, 7'h11);
        expect_beat("top", 64'hABCD_0123, 7'h11, 1'b0, 1'b0);
        expect_beat("oor", 64'h0, 7'h11, 1'b1, 1'b1);
        wait_idle();

        // Low address bits below the word size are ignored
        send_req(49'h1B, 8'd0, 7'h12);
        expect_beat("unalign", 64'h1003, 7'h12, 1'b0, 1'b1);
        wait_idle();

        // Backpressure held during beat 2 of a 4-beat burst
        send_req(49'h80, 8'd3, 7'h22);
        expect_beat("h0", 64'h2000, 7'h22, 1'b0, 1'b0);
        expect_beat("h1", 64'h2001, 7'h22, 1'b0, 1'b0);
        resp_ready = 1'b0;
        step();
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            stable &= resp_valid && (resp_data == 64'h2002) && !resp_last && (resp_id == 7'h22);
            step();
        end
        chk("hold_stable", stable, 1);
        resp_ready = 1'b1;
        expect_beat("h2", 64'h2002, 7'h22, 1'b0, 1'b0);
        expect_beat("h3", 64'h2003, 7'h22, 1'b0, 1'b1);
        wait_idle();

        // FIFO fill behind a stalled burst, then in-order drain
        resp_ready = 1'b0;
        send_req(49'h0, 8'd0, 7'h30);
        n = 0;
        while (!resp_valid && n < 20) begin step(); n++; end
        chk("blk_vld", resp_valid, 1);
        acc = 0;
        req_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            req_addr = 49'(i * 8); req_len = 8'd0; req_id = 7'(i);
            if (!req_ready) break;
            step();
            acc++;
        end
        chk("fifo_accepts", 64'(acc), 4);
        chk("req_rdy_full", req_ready, 0);
        resp_ready = 1'b1;
        fork
            begin
                for (int k = 0; k < 100; k++) begin
                    if (req_ready) begin step(); break; end
                    step();
                end
                req_valid = 1'b0;
            end
            begin
                expect_beat("blk", 64'h1000, 7'h30, 1'b0, 1'b1);
                for (int j = 1; j <= 5; j++)
                    expect_beat("order", 64'h1000 + 64'(j), 7'(j), 1'b0, 1'b1);
            end
        join
        wait_idle();

        // Reset mid-burst with two requests queued
        resp_ready = 1'b0;
        send_req(49'h0, 8'd3, 7'h41);
        send_req(49'h8, 8'd0, 7'h42);
        send_req(49'h10, 8'd0, 7'h43);
        n = 0;
        while (!resp_valid && n < 20) begin step(); n++; end
        chk("pre_rst_vld", resp_valid, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mrst_vld", resp_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_rdy", req_ready, 1);
        resp_ready = 1'b1;
        send_req(49'h10, 8'd0, 7'h44);
        expect_beat("post_rst", 64'h1002, 7'h44, 1'b0, 1'b1);
        wait_idle();

        // Preload write in the same cycle LOAD reads index 4
        send_req(49'h20, 8'd0, 7'h55);
        step(); step(); step(); step();
        init_we = 1'b1; init_addr = 10'd4; init_data = 64'hDEAD;
        step();
        init_we = 1'b0;
        expect_beat("wr_old", 64'h1004, 7'h55, 1'b0, 1'b1);
        wait_idle();
        send_req(49'h20, 8'd0, 7'h56);
        expect_beat("wr_new", 64'hDEAD, 7'h56, 1'b0, 1'b1);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
